gb_fb_bank_scheduler: RTL and testbench
=======================================

Name: gb_fb_bank_scheduler

Overview:
- Triple-buffer bank scheduler for the Game Boy frame buffer.
- Sequences capture writes into one 160x144 bank and commits completed frames.
- Hands the newest complete frame to the HDMI scaler at the scaler's frame start, so a torn frame is never displayed.
- Sits between the Game Boy pixel stream and the shared 3-bank 2-bit pixel BRAM. The reader's frame-start pulse is already synchronised into clk.

Parameters:
- GB_WIDTH, 160, pixels per line
- GB_HEIGHT, 144, lines per frame
- OFS_BITS, 15, bank offset width; must satisfy 2^OFS_BITS >= GB_WIDTH*GB_HEIGHT

Ports:
- clk  in  1  system clock; Game Boy domain
- reset  in  1  synchronous, active-high
- gameboy_vs  in  1  vertical sync level; a rising edge marks frame start
- gameboy_valid  in  1  pixel strobe
- gameboy_pixel  in  2  pixel data
- rd_frame_start  in  1  one-cycle pulse, reader begins a new output frame
- wr_en  out  1  BRAM write enable
- wr_addr  out  2+OFS_BITS  {bank[1:0], offset}
- wr_data  out  2  pixel to write
- rd_bank  out  2  bank the reader must scan
- synced  out  1  high once first vsync edge is seen after reset
- short_frame  out  1  pulse, frame ended with fewer than GB_WIDTH*GB_HEIGHT pixels
- overflow  out  1  pulse, pixel arrived after the frame was full
- frames_dropped  out  8  saturating count of committed frames overwritten before being read

Behaviour:
- Clocking and reset: one clock is used. Reset is synchronous and active-high.
- Reset values:
  - wr_en=0, wr_addr=0, wr_data=0
  - short_frame=0, overflow=0, synced=0, frames_dropped=0
  - bank registers W=0 (writer), R=1 (reader), S=2 (spare)
  - fresh=0, offset=0
  - rd_bank=1
- Invariant: W, R and S are always distinct, with values in {0,1,2}.
- Edge detection: vs_rise = gameboy_vs & ~gameboy_vs_q, where gameboy_vs_q is registered gameboy_vs. gameboy_vs_q resets to 0.
- Capture FSM states: ALIGN, CAPTURE, FULL.
  - ALIGN: pixels are ignored (wr_en=0). On vs_rise go to CAPTURE, set synced=1, offset=0, with no commit.
  - CAPTURE:
    - On gameboy_valid, write the pixel at the current offset and increment offset.
    - When the write at offset GB_WIDTH*GB_HEIGHT-1 occurs, go to FULL.
    - On vs_rise while in CAPTURE: pulse short_frame for 1 cycle, offset=0, no commit, and stay in CAPTURE. The same bank W is reused.
  - FULL:
    - gameboy_valid gives wr_en=0 and a 1-cycle overflow pulse.
    - On vs_rise: commit, offset=0, go to CAPTURE.
- Pixel on the vs_rise cycle: it belongs to the NEW frame. It is written at offset 0 of the post-update W; offset then becomes 1.
- Write port latency: wr_en, wr_addr and wr_data are registered, appearing 1 cycle after the gameboy_valid cycle. wr_addr uses the bank value in effect after that cycle's updates.
- Commit: swap W and S, set fresh=1. If fresh was already 1, increment frames_dropped, saturating at 255.
- Reader switch: on rd_frame_start with fresh=1, swap R and S and clear fresh. With fresh=0, nothing changes.
- rd_bank equals R, registered. It changes only on the cycle after an accepted rd_frame_start.
- Commit and rd_frame_start in the same cycle: commit is applied first, then the switch.
  - Result: W'=S, R'=old W, S'=old R, fresh'=0.
  - frames_dropped increments if the old fresh was 1.
- rd_frame_start in ALIGN is legal and follows the same fresh rule.
- Reset mid-frame: all state returns to reset values. FSM returns to ALIGN; the partial frame is discarded.
- The offset counter never exceeds GB_WIDTH*GB_HEIGHT-1. There is no wrap into the next bank.

Test Plan:
- Reset, then 3 complete frames of 23040 pixels (vs_rise before each), with rd_frame_start after each commit → banks cycle; rd_bank sequence 1→0→2→1; frames_dropped=0; no pulses.
- Pixels before first vs_rise → wr_en stays 0, synced=0. First vs_rise → synced=1 and next pixel written at wr_addr={0,0}.
- Frame of 20000 pixels then vs_rise → short_frame pulse 1 cycle; W unchanged; next pixel written at offset 0 of the same bank; rd_bank unchanged after rd_frame_start.
- 23045 pixels in one frame → 5 overflow pulses, last write at offset 23039, then vs_rise commits normally.
- Two commits with no rd_frame_start → frames_dropped=1. Then rd_frame_start → rd_bank switches to the newest frame.
- vs_rise (from FULL) and rd_frame_start in the same cycle, starting from W=0,R=1,S=2, fresh=0 → W=2, R=0, S=1, fresh=0, rd_bank=0 next cycle.

Source files
------------

// File: rtl/gb_fb_bank_scheduler.sv
// Triple-buffer bank scheduler: steers Game Boy pixels into a writer bank, commits
// finished frames and hands the newest complete frame to the reader at its frame start.
module gb_fb_bank_scheduler #(
    parameter int GB_WIDTH  = 160,
    parameter int GB_HEIGHT = 144,
    parameter int OFS_BITS  = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  gameboy_vs,
    input  logic                  gameboy_valid,
    input  logic [1:0]            gameboy_pixel,
    input  logic                  rd_frame_start,
    output logic                  wr_en,
    output logic [OFS_BITS+1:0]   wr_addr,
    output logic [1:0]            wr_data,
    output logic [1:0]            rd_bank,
    output logic                  synced,
    output logic                  short_frame,
    output logic                  overflow,
    output logic [7:0]            frames_dropped
);

    localparam int FRAME_PIXELS = GB_WIDTH * GB_HEIGHT;
    localparam logic [OFS_BITS-1:0] LAST_OFS = OFS_BITS'(FRAME_PIXELS - 1);

    typedef enum logic [1:0] {ALIGN, CAPTURE, FULL} state_t;

    state_t              state, state_next;
    logic [1:0]          w_bank, r_bank, s_bank;
    logic [1:0]          w_next, r_next, s_next;
    logic                fresh, fresh_next;
    logic [OFS_BITS-1:0] offset, offset_next, wr_ofs;
    logic                vs_q, vs_rise, commit;
    logic                wr_next, ovf_next, short_next, drop_inc;

    always_comb begin
        vs_rise     = gameboy_vs & ~vs_q;
        state_next  = state;
        offset_next = offset;
        wr_ofs      = offset;
        wr_next     = 1'b0;
        ovf_next    = 1'b0;
        short_next  = 1'b0;
        commit      = 1'b0;

        case (state)
            ALIGN:   if (vs_rise) state_next = CAPTURE;
            CAPTURE: if (vs_rise) short_next = 1'b1;
            FULL: begin
                if (vs_rise) begin
                    commit     = 1'b1;
                    state_next = CAPTURE;
                end else if (gameboy_valid) begin
                    ovf_next = 1'b1;
                end
            end
            default: state_next = ALIGN;
        endcase

        // A pixel on the vsync edge is the first pixel of the new frame.
        if (vs_rise) begin
            wr_ofs      = '0;
            offset_next = '0;
            if (gameboy_valid) begin
                wr_next     = 1'b1;
                offset_next = OFS_BITS'(1);
            end
        end else if (state == CAPTURE && gameboy_valid) begin
            wr_next = 1'b1;
            if (offset == LAST_OFS) state_next = FULL;
            else                    offset_next = offset + 1'b1;
        end
    end

    // Commit is applied before the reader switch when both land in one cycle.
    always_comb begin
        w_next     = w_bank;
        r_next     = r_bank;
        s_next     = s_bank;
        fresh_next = fresh;
        drop_inc   = 1'b0;
        if (commit) begin
            w_next     = s_bank;
            s_next     = w_bank;
            fresh_next = 1'b1;
            drop_inc   = fresh;
        end
        if (rd_frame_start && fresh_next) begin
            r_next     = s_next;
            s_next     = r_bank;
            fresh_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ALIGN;
            w_bank         <= 2'd0;
            r_bank         <= 2'd1;
            s_bank         <= 2'd2;
            fresh          <= 1'b0;
            offset         <= '0;
            vs_q           <= 1'b0;
            synced         <= 1'b0;
            wr_en          <= 1'b0;
            wr_addr        <= '0;
            wr_data        <= 2'd0;
            rd_bank        <= 2'd1;
            short_frame    <= 1'b0;
            overflow       <= 1'b0;
            frames_dropped <= 8'd0;
        end else begin
            state       <= state_next;
            w_bank      <= w_next;
            r_bank      <= r_next;
            s_bank      <= s_next;
            fresh       <= fresh_next;
            offset      <= offset_next;
            vs_q        <= gameboy_vs;
            wr_en       <= wr_next;
            rd_bank     <= r_next;
            short_frame <= short_next;
            overflow    <= ovf_next;
            if (vs_rise) synced <= 1'b1;
            if (wr_next) begin
                wr_addr <= {w_next, wr_ofs};
                wr_data <= gameboy_pixel;
            end
            if (drop_inc && frames_dropped != 8'hFF)
                frames_dropped <= frames_dropped + 8'd1;
        end
    end

endmodule

// File: tb/tb_gb_fb_bank_scheduler.sv
// Self-checking bench for gb_fb_bank_scheduler using a small frame geometry and
// a frame-level reference model (pixel counts and bank roles).
module tb_gb_fb_bank_scheduler;

    localparam int GBW       = 20;
    localparam int GBH       = 12;
    localparam int OFS       = 15;
    localparam int TOTAL     = GBW * GBH;
    localparam int SHORT_PIX = 200;

    typedef struct packed {
        logic       rst;
        logic       vs;
        logic       valid;
        logic [1:0] pix;
        logic       rfs;
        logic [1:0] tag;
    } stim_t;

    logic          clk = 1'b0;
    logic          reset, gameboy_vs, gameboy_valid, rd_frame_start;
    logic [1:0]    gameboy_pixel;
    logic          wr_en, synced, short_frame, overflow;
    logic [OFS+1:0] wr_addr;
    logic [1:0]    wr_data, rd_bank;
    logic [7:0]    frames_dropped;

    int checks = 0;
    int failures = 0;
    stim_t q[$];

    int m_w, m_r, m_s, m_count, m_dropped;
    bit m_fresh, m_synced, m_vs_prev;
    logic [32:0] expv;

    gb_fb_bank_scheduler #(.GB_WIDTH(GBW), .GB_HEIGHT(GBH), .OFS_BITS(OFS)) dut (
        .clk(clk), .reset(reset), .gameboy_vs(gameboy_vs), .gameboy_valid(gameboy_valid),
        .gameboy_pixel(gameboy_pixel), .rd_frame_start(rd_frame_start), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .rd_bank(rd_bank), .synced(synced),
        .short_frame(short_frame), .overflow(overflow), .frames_dropped(frames_dropped)
    );

    always #5 clk = ~clk;

    function automatic logic [32:0] observed();
        return {wr_en, wr_en ? {wr_addr, wr_data} : 19'd0, rd_bank, synced,
                short_frame, overflow, frames_dropped};
    endfunction

    // Frame-level model: a frame is full once TOTAL pixels were accepted.
    task automatic model_step(input stim_t s);
        bit rise, e_wr, e_short, e_ovf;
        logic [16:0] e_addr;
        logic [1:0] e_data;
        int t;
        if (s.rst) begin
            m_w = 0; m_r = 1; m_s = 2; m_count = 0; m_dropped = 0;
            m_fresh = 0; m_synced = 0; m_vs_prev = 0;
            expv = {1'b0, 19'd0, 2'd1, 1'b0, 1'b0, 1'b0, 8'd0};
            return;
        end
        e_wr = 0; e_short = 0; e_ovf = 0; e_addr = '0; e_data = '0;
        rise = s.vs && !m_vs_prev;
        m_vs_prev = s.vs;
        if (rise) begin
            if (m_synced && m_count == TOTAL) begin
                if (m_fresh) m_dropped = (m_dropped >= 255) ? 255 : m_dropped + 1;
                t = m_w; m_w = m_s; m_s = t;
                m_fresh = 1;
            end else if (m_synced) begin
                e_short = 1;
            end
            m_synced = 1;
            m_count = 0;
        end
        if (s.valid && m_synced) begin
            if (m_count < TOTAL) begin
                e_wr = 1;
                e_addr = 17'(m_w * (1 << OFS) + m_count);
                e_data = s.pix;
                m_count++;
            end else begin
                e_ovf = 1;
            end
        end
        if (s.rfs && m_fresh) begin
            t = m_r; m_r = m_s; m_s = t;
            m_fresh = 0;
        end
        expv = {e_wr, e_wr ? {e_addr, e_data} : 19'd0, 2'(m_r), m_synced, e_short, e_ovf, 8'(m_dropped)};
    endtask

    task automatic drive_cycle(input stim_t s);
        reset = s.rst; gameboy_vs = s.vs; gameboy_valid = s.valid;
        gameboy_pixel = s.pix; rd_frame_start = s.rfs;
        model_step(s);
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic rst, input logic vs, input logic valid,
                       input logic [1:0] pix, input logic rfs, input logic [1:0] tag);
        stim_t s;
        s.rst = rst; s.vs = vs; s.valid = valid; s.pix = pix; s.rfs = rfs; s.tag = tag;
        q.push_back(s);
    endtask

    task automatic add_pixels(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) add(0, 0, 0, 2'd0, 0, 2'd0);
            add(0, 0, 1, 2'($urandom_range(0, 3)), 0, 2'd0);
        end
    endtask

    task automatic add_frame(input int npix, input bit rfs_after, input bit rise_pix_ok);
        bit on_rise;
        on_rise = rise_pix_ok && npix > 0 && $urandom_range(0, 1) == 1;
        add(0, 1, on_rise, 2'($urandom_range(0, 3)), 0, 2'd0);
        if (rfs_after) add(0, 0, 0, 2'd0, 1, 2'd1);
        add_pixels(npix - int'(on_rise), 1);
    endtask

    task automatic test_reset();
        q.delete();
        for (int i = 0; i < 3; i++)
            add(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 2'd0);
        foreach (q[i]) begin
            drive_cycle(q[i]);
            checks++;
            if (observed() !== expv) begin
                failures++;
                $display("[TB] FAIL test_reset cycle %0d: got %h expected %h", i, observed(), expv);
            end
        end
        checks++;
        if ({wr_en, wr_addr, wr_data, synced, short_frame, overflow, frames_dropped, rd_bank} !== {31'd0, 2'd1}) begin
            failures++;
            $display("[TB] FAIL test_reset values: got wr_addr=%h rd_bank=%0d synced=%b dropped=%0d expected 0/1/0/0",
                     wr_addr, rd_bank, synced, frames_dropped);
        end
    endtask

    task automatic test_align();
        q.delete();
        for (int i = 0; i < 10; i++) add(0, 0, 1, 2'($urandom_range(0, 3)), 0, (i == 9) ? 2'd2 : 2'd0);
        add(0, 1, 0, 2'd0, 0, 2'd0);
        add(0, 0, 1, 2'($urandom_range(0, 3)), 0, 2'd1);
        foreach (q[i]) begin
            drive_cycle(q[i]);
            checks++;
            if (observed() !== expv) begin
                failures++;
                $display("[TB] FAIL test_align cycle %0d: got %h expected %h", i, observed(), expv);
            end
            if (q[i].tag == 2'd2) begin
                checks++;
                if (wr_en !== 1'b0 || synced !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL test_align pre-sync: got wr_en=%b synced=%b expected 0 0", wr_en, synced);
                end
            end
            if (q[i].tag == 2'd1) begin
                checks++;
                if (wr_en !== 1'b1 || wr_addr !== 17'd0 || synced !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL test_align first write: got wr_en=%b wr_addr=%h synced=%b expected 1 0 1",
                             wr_en, wr_addr, synced);
                end
            end
        end
    endtask

    task automatic test_full_frames();
        int seq[3];
        int n, pulses;
        seq[0] = 0; seq[1] = 2; seq[2] = 1;
        n = 0; pulses = 0;
        q.delete();
        add(1, 0, 0, 2'd0, 0, 2'd0);
        add_frame(TOTAL, 0, 0);
        add_frame(TOTAL, 1, 1);
        add_frame(TOTAL, 1, 1);
        add_frame(0, 1, 1);
        foreach (q[i]) begin
            drive_cycle(q[i]);
            checks++;
            if (observed() !== expv) begin
                failures++;
                $display("[TB] FAIL test_full_frames cycle %0d: got %h expected %h", i, observed(), expv);
            end
            pulses += int'(short_frame) + int'(overflow);
            if (q[i].tag == 2'd1 && n < 3) begin
                checks++;
                if (rd_bank !== 2'(seq[n])) begin
                    failures++;
                    $display("[TB] FAIL test_full_frames rd_bank step %0d: got %0d expected %0d", n, rd_bank, seq[n]);
                end
                n++;
            end
        end
        checks++;
        if (pulses != 0 || frames_dropped !== 8'd0 || n != 3) begin
            failures++;
            $display("[TB] FAIL test_full_frames summary: got pulses=%0d dropped=%0d switches=%0d expected 0 0 3",
                     pulses, frames_dropped, n);
        end
    endtask

    task automatic test_short_frame();
        logic [1:0] save_bank, save_rd;
        save_bank = 2'd0; save_rd = 2'd0;
        q.delete();
        add_pixels(SHORT_PIX - 1, 1);
        add(0, 0, 1, 2'($urandom_range(0, 3)), 0, 2'd3);
        add(0, 1, 1, 2'($urandom_range(0, 3)), 0, 2'd2);
        add(0, 0, 0, 2'd0, 0, 2'd0);
        add(0, 0, 0, 2'd0, 1, 2'd1);
        foreach (q[i]) begin
            drive_cycle(q[i]);
            checks++;
            if (observed() !== expv) begin
                failures++;
                $display("[TB] FAIL test_short_frame cycle %0d: got %h expected %h", i, observed(), expv);
            end
            if (q[i].tag == 2'd3) begin
                save_bank = wr_addr[16:15];
                save_rd = rd_bank;
            end
            if (q[i].tag == 2'd2) begin
                checks++;
                if (short_frame !== 1'b1 || wr_en !== 1'b1 || wr_addr !== {save_bank, 15'd0}) begin
                    failures++;
                    $display("[TB] FAIL test_short_frame restart: got short=%b wr_en=%b wr_addr=%h expected 1 1 %h",
                             short_frame, wr_en, wr_addr, {save_bank, 15'd0});
                end
            end
            if (q[i].tag == 2'd1) begin
                checks++;
                if (rd_bank !== save_rd) begin
                    failures++;
                    $display("[TB] FAIL test_short_frame rd_bank: got %0d expected %0d", rd_bank, save_rd);
                end
            end
        end
    endtask

    task automatic test_overflow();
        int ovf_seen, last_ofs;
        ovf_seen = 0; last_ofs = -1;
        q.delete();
        add_frame(TOTAL + 5, 0, 1);
        add(0, 1, 0, 2'd0, 0, 2'd0);
        add(0, 0, 0, 2'd0, 0, 2'd0);
        foreach (q[i]) begin
            drive_cycle(q[i]);
            checks++;
            if (observed() !== expv) begin
                failures++;
                $display("[TB] FAIL test_overflow cycle %0d: got %h expected %h", i, observed(), expv);
            end
            ovf_seen += int'(overflow);
            if (wr_en === 1'b1) last_ofs = int'(wr_addr[14:0]);
        end
        checks++;
        if (ovf_seen != 5 || last_ofs != TOTAL - 1) begin
            failures++;
            $display("[TB] FAIL test_overflow: got pulses=%0d last_ofs=%0d expected 5 %0d", ovf_seen, last_ofs, TOTAL - 1);
        end
    endtask

    task automatic test_dropped();
        logic [1:0] newest;
        newest = 2'd3;
        q.delete();
        add(0, 0, 0, 2'd0, 1, 2'd0);
        add_pixels(TOTAL, 1);
        add(0, 1, 0, 2'd0, 0, 2'd0);
        add_pixels(TOTAL - 1, 1);
        add(0, 0, 1, 2'($urandom_range(0, 3)), 0, 2'd3);
        add(0, 1, 0, 2'd0, 0, 2'd0);
        add(0, 0, 0, 2'd0, 1, 2'd1);
        foreach (q[i]) begin
            drive_cycle(q[i]);
            checks++;
            if (observed() !== expv) begin
                failures++;
                $display("[TB] FAIL test_dropped cycle %0d: got %h expected %h", i, observed(), expv);
            end
            if (q[i].tag == 2'd3) newest = wr_addr[16:15];
            if (q[i].tag == 2'd1) begin
                checks++;
                if (rd_bank !== newest || frames_dropped !== 8'd1) begin
                    failures++;
                    $display("[TB] FAIL test_dropped: got rd_bank=%0d dropped=%0d expected %0d 1",
                             rd_bank, frames_dropped, newest);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        q.delete();
        add(1, 0, 0, 2'd0, 0, 2'd0);
        add(0, 1, 0, 2'd0, 0, 2'd0);
        add_pixels(TOTAL, 1);
        add(0, 1, 0, 2'd0, 1, 2'd1);
        add(0, 0, 1, 2'($urandom_range(0, 3)), 0, 2'd2);
        add_pixels(30, 1);
        add(1, 0, 0, 2'd0, 0, 2'd0);
        add(0, 0, 1, 2'($urandom_range(0, 3)), 0, 2'd3);
        foreach (q[i]) begin
            drive_cycle(q[i]);
            checks++;
            if (observed() !== expv) begin
                failures++;
                $display("[TB] FAIL test_back_to_back cycle %0d: got %h expected %h", i, observed(), expv);
            end
            if (q[i].tag == 2'd1) begin
                checks++;
                if (rd_bank !== 2'd0) begin
                    failures++;
                    $display("[TB] FAIL test_back_to_back rd_bank: got %0d expected 0", rd_bank);
                end
            end
            if (q[i].tag == 2'd2) begin
                checks++;
                if (wr_en !== 1'b1 || wr_addr !== {2'd2, 15'd0}) begin
                    failures++;
                    $display("[TB] FAIL test_back_to_back writer: got wr_en=%b wr_addr=%h expected 1 %h",
                             wr_en, wr_addr, {2'd2, 15'd0});
                end
            end
            if (q[i].tag == 2'd3) begin
                checks++;
                if (wr_en !== 1'b0 || rd_bank !== 2'd1 || synced !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL test_back_to_back mid-frame reset: got wr_en=%b rd_bank=%0d synced=%b expected 0 1 0",
                             wr_en, rd_bank, synced);
                end
            end
        end
    endtask

    task automatic test_saturation();
        q.delete();
        add(1, 0, 0, 2'd0, 0, 2'd0);
        add(0, 1, 0, 2'd0, 0, 2'd0);
        for (int k = 0; k < 260; k++) begin
            add_pixels(TOTAL, 0);
            add(0, 1, 0, 2'd0, 0, 2'd0);
        end
        foreach (q[i]) begin
            drive_cycle(q[i]);
            checks++;
            if (observed() !== expv) begin
                failures++;
                $display("[TB] FAIL test_saturation cycle %0d: got %h expected %h", i, observed(), expv);
            end
        end
        checks++;
        if (frames_dropped !== 8'd255) begin
            failures++;
            $display("[TB] FAIL test_saturation: got dropped=%0d expected 255", frames_dropped);
        end
    endtask

    task automatic test_random();
        logic vs;
        vs = 1'b0;
        q.delete();
        add(1, 0, 0, 2'd0, 0, 2'd0);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 149) == 0) vs = ~vs;
            add(1'($urandom_range(0, 999) == 0), vs, 1'($urandom_range(0, 3) != 0),
                2'($urandom_range(0, 3)), 1'($urandom_range(0, 49) == 0), 2'd0);
        end
        foreach (q[i]) begin
            drive_cycle(q[i]);
            checks++;
            if (observed() !== expv) begin
                failures++;
                $display("[TB] FAIL test_random cycle %0d: got %h expected %h", i, observed(), expv);
            end
        end
    endtask

    initial begin
        reset = 1'b1; gameboy_vs = 1'b0; gameboy_valid = 1'b0;
        gameboy_pixel = 2'd0; rd_frame_start = 1'b0;
        test_reset();
        test_align();
        test_full_frames();
        test_short_frame();
        test_overflow();
        test_dropped();
        test_back_to_back();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
